// File: rtl/mult_sequencer_if.sv
// Decode-side and multiplier-side signals of the multiply sequencer.
// The sequencer connects through the slave modport, and the decode/multiplier side connects through the master modport.
interface mult_sequencer_if;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;
  logic [5:0]  mulSignal;
  logic [31:0] mulA;
  logic [31:0] mulB;
  logic        mulReset;
  logic [63:0] mulResult;

  modport master (
    output Signal, dataA, dataB, mulResult,
    input  dataOut, busy, done, mulSignal, mulA, mulB, mulReset
  );

  modport slave (
    input  Signal, dataA, dataB, mulResult,
    output dataOut, busy, done, mulSignal, mulA, mulB, mulReset
  );
endinterface

// File: rtl/mult_sequencer.sv
// Sequencer for the 32-cycle shift-add unsigned multiplier: MULTU drives load/iterate/output, MFHI/MFLO read HI/LO.
// Optional feature: define MULTSEQ_ZERO_SKIP_EN to bypass the multiplier when either operand is zero.
module mult_sequencer #(
  parameter int MUL_CYCLES = 32
) (
  input logic             clk,
  input logic             reset,
  mult_sequencer_if.slave bus
);
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] MS_IDLE  = 6'd0;
  localparam logic [5:0] MS_MULTU = 6'd25;
  localparam logic [5:0] MS_OUT   = 6'd63;
  localparam int         CNT_W    = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MUL_CYCLES);

`ifdef MULTSEQ_ZERO_SKIP_EN
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_OUT, S_CAPT, S_ZERO} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT, S_CAPT} state_t;
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [5:0]       r_mulSignal;
  logic [31:0]      r_mulA;
  logic [31:0]      r_mulB;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_dataOut;
  logic             w_multu;

  assign w_multu = (bus.Signal == FN_MULTU);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mulSignal <= MS_IDLE;
      r_mulA      <= '0;
      r_mulB      <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_dataOut   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_multu) begin
            r_mulA <= bus.dataA;
            r_mulB <= bus.dataB;
            r_cnt  <= '0;
            r_busy <= 1'b1;
`ifdef MULTSEQ_ZERO_SKIP_EN
            if ((bus.dataA == '0) || (bus.dataB == '0)) begin
              r_state <= S_ZERO;
            end else begin
              r_state     <= S_RUN;
              r_mulSignal <= MS_MULTU;
            end
`else
            r_state     <= S_RUN;
            r_mulSignal <= MS_MULTU;
`endif
          end
        end
        // cnt 0 is the load cycle, 1..MUL_CYCLES are the iterate cycles
        S_RUN: begin
          if (r_cnt == CNT_MAX) begin
            r_state     <= S_OUT;
            r_mulSignal <= MS_OUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_OUT: r_state <= S_CAPT;
        S_CAPT: begin
          {r_hi, r_lo} <= bus.mulResult;
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
          r_mulSignal  <= MS_IDLE;
          r_state      <= S_IDLE;
        end
`ifdef MULTSEQ_ZERO_SKIP_EN
        S_ZERO: begin
          r_hi    <= '0;
          r_lo    <= '0;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase

      // Reads see the pre-edge HI/LO, so a read on the capture edge returns the old product
      if (bus.Signal == FN_MFHI) begin
        r_dataOut <= r_hi;
      end else if (bus.Signal == FN_MFLO) begin
        r_dataOut <= r_lo;
      end
    end
  end

  assign bus.dataOut   = r_dataOut;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.mulSignal = r_mulSignal;
  assign bus.mulA      = r_mulA;
  assign bus.mulB      = r_mulB;
  assign bus.mulReset  = reset;
endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural shift-add multiplier and a product scoreboard.
module tb_mult_sequencer;
  localparam logic [5:0] MULTU = 6'd25;
  localparam logic [5:0] MFHI  = 6'd16;
  localparam logic [5:0] MFLO  = 6'd18;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ndone = 0;
  logic [63:0] sb[$];

  mult_sequencer_if bus();

  mult_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.done) ndone <= ndone + 1;
  end

  // Multiplier model: first MULTU cycle loads, next 32 iterate, OUT registers the product
  logic [63:0] m_acc;
  logic [31:0] m_a, m_b;
  logic        m_loaded;
  int          m_it;
  always @(posedge clk or posedge bus.mulReset) begin
    if (bus.mulReset) begin
      m_acc <= '0; m_a <= '0; m_b <= '0; m_loaded <= 1'b0; m_it <= 0;
      bus.mulResult <= '0;
    end else if (bus.mulSignal == 6'd25) begin
      if (!m_loaded) begin
        m_acc <= '0; m_a <= bus.mulA; m_b <= bus.mulB; m_loaded <= 1'b1; m_it <= 0;
      end else if (m_it < 32) begin
        if (m_b[m_it]) m_acc <= m_acc + ({32'b0, m_a} << m_it);
        m_it <= m_it + 1;
      end
    end else if (bus.mulSignal == 6'd63) begin
      bus.mulResult <= m_acc;
      m_loaded      <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
    bus.Signal = code;
    bus.dataA  = a;
    bus.dataB  = b;
    tick();
    bus.Signal = 6'd0;
  endtask

  task automatic wait_done(input int e0, output int lat, output int n25, output int n63);
    n25 = 0;
    n63 = 0;
    while (!bus.done && (cyc - e0) < 200) begin
      if (bus.mulSignal == 6'd25) n25++;
      if (bus.mulSignal == 6'd63) n63++;
      tick();
    end
    lat = cyc - e0;
  endtask

  task automatic pop_exp(output logic [63:0] exp);
    if (sb.size() > 0) exp = sb.pop_front();
    else exp = 'x;
  endtask

  initial begin
    int e0, lat, n25, n63, nd0;
    logic [63:0] exp;

    reset = 1'b1;
    bus.Signal = '0; bus.dataA = '0; bus.dataB = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_mulSignal", bus.mulSignal, 0);
    check("rst_mulAB", {bus.mulA, bus.mulB}, 0);
    check("rst_dataOut", bus.dataOut, 0);

    // 3 x 5: timing of mulSignal phases and done
    issue(MULTU, 32'd3, 32'd5);
    sb.push_back(64'd15);
    e0 = cyc;
    check("t1_busy", bus.busy, 1);
    check("t1_mulA", bus.mulA, 3);
    wait_done(e0, lat, n25, n63);
    check("t1_done_lat", lat, 35);
    check("t1_n_multu", n25, 33);
    check("t1_n_out", n63, 2);
    check("t1_busy_at_done", bus.busy, 0);
    tick();
    check("t1_done_pulse", bus.done, 0);
    pop_exp(exp);
    issue(MFLO, 0, 0);
    check("t1_mflo", bus.dataOut, exp[31:0]);
    issue(MFHI, 0, 0);
    check("t1_mfhi", bus.dataOut, exp[63:32]);

    // Full-width operands
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    sb.push_back(64'hFFFF_FFFE_0000_0001);
    e0 = cyc;
    wait_done(e0, lat, n25, n63);
    check("t2_done_lat", lat, 35);
    pop_exp(exp);
    issue(MFHI, 0, 0);
    check("t2_mfhi", bus.dataOut, exp[63:32]);
    issue(MFLO, 0, 0);
    check("t2_mflo", bus.dataOut, exp[31:0]);

    // Overlapping MULTU ignored, read during busy, read on the capture edge
    nd0 = ndone;
    issue(MULTU, 32'd2, 32'd4);
    sb.push_back(64'd8);
    e0 = cyc;
    repeat (4) tick();
    issue(MULTU, 32'd7, 32'd9);
    issue(MFLO, 0, 0);
    check("t3_mflo_busy", bus.dataOut, 32'h0000_0001);
    check("t3_mulB_held", bus.mulB, 4);
    while ((cyc - e0) < 34) tick();
    bus.Signal = MFHI;
    tick();
    bus.Signal = 6'd0;
    check("t3_done_at_capt", bus.done, 1);
    check("t3_mfhi_old", bus.dataOut, 32'hFFFF_FFFE);
    repeat (40) tick();
    check("t3_single_done", ndone - nd0, 1);
    check("t3_idle", bus.busy, 0);
    pop_exp(exp);
    issue(MFLO, 0, 0);
    check("t3_mflo", bus.dataOut, exp[31:0]);
    issue(MFHI, 0, 0);
    check("t3_mfhi", bus.dataOut, exp[63:32]);

    // Asynchronous reset in the middle of RUN
    issue(MULTU, 32'd11, 32'd13);
    sb.push_back(64'd143);
    repeat (10) tick();
    nd0 = ndone;
    reset = 1'b1;
    #1;
    check("t4_busy", bus.busy, 0);
    check("t4_mulSignal", bus.mulSignal, 0);
    check("t4_dataOut", bus.dataOut, 0);
    check("t4_mulReset", bus.mulReset, 1);
    sb.delete();
    #2;
    reset = 1'b0;
    tick();
    check("t4_mulReset_rel", bus.mulReset, 0);
    issue(MFHI, 0, 0);
    check("t4_hi_cleared", bus.dataOut, 0);
    issue(MFLO, 0, 0);
    check("t4_lo_cleared", bus.dataOut, 0);
    check("t4_no_done", ndone - nd0, 0);
    issue(MULTU, 32'd6, 32'd7);
    sb.push_back(64'd42);
    e0 = cyc;
    wait_done(e0, lat, n25, n63);
    check("t4_done_lat", lat, 35);
    pop_exp(exp);
    issue(MFLO, 0, 0);
    check("t4_mflo", bus.dataOut, exp[31:0]);

    // Zero operand
    issue(MULTU, 32'd0, 32'h1234);
    sb.push_back(64'd0);
    e0 = cyc;
    wait_done(e0, lat, n25, n63);
`ifdef MULTSEQ_ZERO_SKIP_EN
    check("t5_done_lat", lat, 1);
    check("t5_mulSignal_quiet", n25 + n63, 0);
`else
    check("t5_done_lat", lat, 35);
`endif
    pop_exp(exp);
    issue(MFLO, 0, 0);
    check("t5_mflo", bus.dataOut, exp[31:0]);
    issue(MFHI, 0, 0);
    check("t5_mfhi", bus.dataOut, exp[63:32]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
